waveform_capture: RTL and testbench
===================================

# waveform_capture

Capture controller sitting between the ADC sample stream and the PMT ring buffer (`ringbuffer`, SIZE/WIDTH matched). It keeps the ring buffer writing continuously and detects a trigger, either a rising threshold crossing on the sample stream or an external pulse. It then lets POST-1 more samples in, freezes writes, and streams the PRE+POST-sample window (oldest first) out over a valid/ready interface. It owns the ring buffer's `wr_en`, `rd_en` and `ain`, and consumes its `aout` and `dout`.

## Interface
- `SIZE`, 8: ring buffer address width; depth 2**SIZE.
- `WIDTH`, 14: sample width.
- `PRE`, 16: samples kept before the trigger sample (0 ≤ PRE).
- `POST`, 48: samples from the trigger sample on, inclusive (1 ≤ POST; PRE+POST ≤ 2**SIZE).
- `clk` in, 1: single clock; all logic on posedge.
- `rst` in, 1: synchronous, active-high reset. The same net also resets the ring buffer.
- `adc_in` in, WIDTH: sample presented this cycle; written by the ring buffer when `rb_wr_en`=1.
- `threshold` in, WIDTH: unsigned self-trigger level; may change at any time.
- `ext_trig` in, 1: external trigger, level-sampled each cycle.
- `rb_aout` in, SIZE: ring buffer write address (address the current sample lands at).
- `rb_dout` in, WIDTH: ring buffer combinational read data for `rb_ain`.
- `rb_wr_en` out, 1: ring buffer write enable.
- `rb_rd_en` out, 1: ring buffer read enable.
- `rb_ain` out, SIZE: ring buffer read address.
- `out_data` out, WIDTH: window sample.
- `out_valid` out, 1: `out_data` valid.
- `out_ready` in, 1: consumer accepts when `out_valid`&&`out_ready`.
- `out_first` out, 1: marks the oldest sample of the window.
- `out_last` out, 1: marks the final sample of the window.
- `busy` out, 1: high in POST and READ.
- `trig_count` out, 16: accepted triggers, wraps at 2**16.

## Operation
- States: FILL → ARMED → POST → READ → FILL.
- FILL:
  - `rb_wr_en`=1; a fill counter counts written samples.
  - Moves to ARMED once PRE samples have been written (immediately if PRE=0).
  - Triggers are ignored.
- ARMED:
  - `rb_wr_en`=1.
  - Trigger = `ext_trig` OR (`adc_in` > `threshold` AND previous written sample ≤ `threshold`). Comparisons are unsigned.
  - The "previous sample" register updates on every written sample. After reset it is all-ones, so no crossing fires on the first sample.
  - On trigger:
    - latch start = `rb_aout` − PRE, modulo 2**SIZE;
    - `trig_count`+1;
    - go to POST with post counter = POST−1. If POST=1, go straight to READ.
- POST:
  - `rb_wr_en`=1 and the counter decrements per cycle.
  - At the cycle the counter reads 1, next state is READ.
  - Triggers are ignored.
- READ:
  - `rb_wr_en`=0, `rb_rd_en`=1, `rb_ain`=rd_ptr (initialised to start).
  - A single-entry output register loads `rb_dout` whenever it is empty or being consumed this cycle. rd_ptr then increments modulo 2**SIZE.
  - A window counter tracks the PRE+POST loads.
  - `out_first` is set on the load of index 0; `out_last` is set on the load of index PRE+POST−1.
  - When the last word is accepted, go to FILL. The fill counter clears, so PRE fresh samples are required before re-arming.
- `rb_rd_en`=0 and `rb_ain`=0 outside READ.
- Simultaneous `ext_trig` and crossing count as one trigger.
- Reset mid-capture or mid-readout aborts the window: state FILL, any pending `out_valid` is dropped, and no partial-window completion is produced.

## Timing
- Reset values: state FILL, `rb_wr_en`=1 (FILL), `rb_rd_en`=0, `rb_ain`=0, `out_valid`=0, `out_data`=0, `out_first`=0, `out_last`=0, `busy`=0, `trig_count`=0.
- Trigger seen at cycle T; that sample is written at T:
  - writes continue through T+POST−1;
  - `rb_wr_en`=0 from T+POST;
  - state is READ at T+POST;
  - first `out_valid` at T+POST+1.
- With `out_ready` held high: one word per cycle, last word at T+2·POST+PRE, FILL entered the following cycle.
- `out_data`, `out_first` and `out_last` are held stable while `out_valid`&&!`out_ready`.
- Window wrap-around: the addresses of the oldest and newest samples may straddle 2**SIZE−1 → 0, and the read pointer wraps in step.

## Test plan
- **Reset defaults.** Reset, then PRE=16 and 16 ramp samples → `rb_wr_en`=1 throughout; state ARMED after cycle 16; `trig_count`=0; `out_valid` never 1.
- **External trigger.** `ext_trig` pulse on the sample of value 100 (ramp, +1/cycle, SIZE=8, PRE=16, POST=48) → 64 words 84..147 in order; `out_first` on 84, `out_last` on 147; `trig_count`=1.
- **Threshold crossing.** `threshold`=500, samples 490,499,500,501,600 → trigger on 501 only. A second run with the stream held above threshold does not retrigger.
- **Wrap and backpressure.** Trigger placed so the window spans address 255→0, with `out_ready` toggled 1/0 per cycle → 64 contiguous samples, none duplicated or lost, each held while stalled.
- **Ignored triggers.** `ext_trig` pulses during FILL, POST and READ → ignored; `trig_count` unchanged; after READ, re-arming takes 16 cycles.
- **Reset mid-readout.** `rst` after the 10th accepted word → `out_valid`=0 on the next cycle, state FILL, `trig_count`=0; a new trigger yields a complete fresh window.

Source files
------------

// File: rtl/waveform_capture.sv
// Capture controller in front of the ADC ring buffer: keeps the buffer filling,
// triggers on a threshold crossing or external pulse, then streams the window out.
module waveform_capture #(
  parameter int SIZE  = 8,
  parameter int WIDTH = 14,
  parameter int PRE   = 16,
  parameter int POST  = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] adc_in,
  input  logic [WIDTH-1:0] threshold,
  input  logic             ext_trig,
  input  logic [SIZE-1:0]  rb_aout,
  input  logic [WIDTH-1:0] rb_dout,
  output logic             rb_wr_en,
  output logic             rb_rd_en,
  output logic [SIZE-1:0]  rb_ain,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_first,
  output logic             out_last,
  output logic             busy,
  output logic [15:0]      trig_count
);

  // state   | meaning
  // S_FILL  | writing, waiting for PRE fresh samples
  // S_ARMED | writing, watching for a trigger
  // S_POST  | writing the remaining post-trigger samples
  // S_READ  | writes frozen, window streamed out oldest first
  typedef enum logic [1:0] {S_FILL, S_ARMED, S_POST, S_READ} state_t;

  localparam int CW = SIZE + 1;
  localparam logic [CW-1:0]   PRE_LD  = CW'(PRE);
  localparam logic [CW-1:0]   POST_LD = CW'(POST - 1);
  localparam logic [CW-1:0]   WIN_LD  = CW'(PRE + POST);
  localparam logic [SIZE-1:0] PRE_OFS = SIZE'(PRE);

  state_t            state, state_nxt;
  logic [CW-1:0]     fill_cnt;
  logic [CW-1:0]     post_cnt;
  logic [CW-1:0]     win_cnt;
  logic [SIZE-1:0]   rd_ptr;
  logic [WIDTH-1:0]  prev_sample;
  logic              crossing;
  logic              trig;
  logic              load;
  logic              last_accept;

  assign crossing    = (adc_in > threshold) && (prev_sample <= threshold);
  assign trig        = (state == S_ARMED) && (ext_trig || crossing);
  assign load        = (state == S_READ) && (win_cnt != '0) && (!out_valid || out_ready);
  assign last_accept = out_valid && out_ready && out_last;

  always_comb begin
    state_nxt = state;
    rb_wr_en  = 1'b1;
    rb_rd_en  = 1'b0;
    rb_ain    = '0;
    busy      = 1'b0;
    case (state)
      S_FILL: begin
        if (fill_cnt <= CW'(1)) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (trig) state_nxt = (POST == 1) ? S_READ : S_POST;
      end
      S_POST: begin
        busy = 1'b1;
        if (post_cnt <= CW'(1)) state_nxt = S_READ;
      end
      S_READ: begin
        busy     = 1'b1;
        rb_wr_en = 1'b0;
        rb_rd_en = 1'b1;
        rb_ain   = rd_ptr;
        if (last_accept) state_nxt = S_FILL;
      end
      default: state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FILL;
      fill_cnt    <= PRE_LD;
      post_cnt    <= '0;
      win_cnt     <= '0;
      rd_ptr      <= '0;
      prev_sample <= '1;
      trig_count  <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_first   <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (rb_wr_en) prev_sample <= adc_in;

      case (state)
        S_FILL: begin
          if (fill_cnt != '0) fill_cnt <= fill_cnt - CW'(1);
        end
        S_ARMED: begin
          if (trig) begin
            // window starts PRE samples before the trigger sample's address
            rd_ptr     <= rb_aout - PRE_OFS;
            trig_count <= trig_count + 16'd1;
            post_cnt   <= POST_LD;
            win_cnt    <= WIN_LD;
          end
        end
        S_POST: begin
          post_cnt <= post_cnt - CW'(1);
        end
        S_READ: begin
          if (load) begin
            rd_ptr  <= rd_ptr + SIZE'(1);
            win_cnt <= win_cnt - CW'(1);
          end
          if (last_accept) fill_cnt <= PRE_LD;
        end
        default: ;
      endcase

      if (load) begin
        out_data  <= rb_dout;
        out_valid <= 1'b1;
        out_first <= (win_cnt == WIN_LD);
        out_last  <= (win_cnt == CW'(1));
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_waveform_capture.sv
// Directed bench for waveform_capture with a behavioural ring buffer and a
// sample history used to derive the expected capture window.
module tb_waveform_capture;

  localparam int SIZE  = 8;
  localparam int WIDTH = 14;
  localparam int PRE   = 16;
  localparam int POST  = 48;
  localparam int WIN   = PRE + POST;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] adc_in = '0;
  logic [WIDTH-1:0] threshold = '1;
  logic             ext_trig = 1'b0;
  logic [SIZE-1:0]  rb_aout;
  logic [WIDTH-1:0] rb_dout;
  logic             rb_wr_en;
  logic             rb_rd_en;
  logic [SIZE-1:0]  rb_ain;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_first;
  logic             out_last;
  logic             busy;
  logic [15:0]      trig_count;

  int cyc = 0;
  int nsamp = 0;
  int n_checks = 0;
  int n_pass = 0;
  bit ramp = 1'b0;
  logic [WIDTH-1:0] hist [0:1023];
  logic [WIDTH-1:0] rb_mem [0:(1<<SIZE)-1];

  always #5 clk = ~clk;

  waveform_capture #(.SIZE(SIZE), .WIDTH(WIDTH), .PRE(PRE), .POST(POST)) dut (
    .clk(clk), .rst(rst), .adc_in(adc_in), .threshold(threshold), .ext_trig(ext_trig),
    .rb_aout(rb_aout), .rb_dout(rb_dout), .rb_wr_en(rb_wr_en), .rb_rd_en(rb_rd_en),
    .rb_ain(rb_ain), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_first(out_first), .out_last(out_last), .busy(busy), .trig_count(trig_count)
  );

  // ring buffer model: write at rb_aout, combinational read at rb_ain
  always @(posedge clk) begin
    if (rst) rb_aout <= '0;
    else if (rb_wr_en) begin
      rb_mem[rb_aout] <= adc_in;
      rb_aout <= rb_aout + 1'b1;
    end
  end
  assign rb_dout = rb_mem[rb_ain];

  task automatic cycle();
    if (rb_wr_en && !rst && nsamp < 1024) begin
      hist[nsamp] = adc_in;
      nsamp++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (ramp) adc_in = adc_in + 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ramp = 1'b0; adc_in = '0; ext_trig = 1'b0;
    out_ready = 1'b0; threshold = '1;
    cycle();
    cycle();
    rst = 1'b0;
    nsamp = 0;
  endtask

  task automatic wait_value(input int v);
    int g = 0;
    while (int'(adc_in) != v && g < 1000) begin
      cycle();
      g++;
    end
  endtask

  task automatic drain(input int n, input bit toggle, input int base,
                       output int first_c, output int last_c);
    int idx = 0;
    int budget = 0;
    first_c = -1;
    last_c = -1;
    out_ready = 1'b1;
    while (idx < n && budget < 600) begin
      if (out_valid) begin
        n_checks++;
        if (out_data !== hist[base+idx] || out_first !== (idx == 0) || out_last !== (idx == WIN-1))
          $display("FAIL window_word %0d: got data=%0d first=%0b last=%0b, expected data=%0d first=%0b last=%0b",
                   idx, out_data, out_first, out_last, hist[base+idx], (idx == 0), (idx == WIN-1));
        else n_pass++;
        if (out_ready) begin
          if (idx == 0) first_c = cyc;
          last_c = cyc;
          idx++;
        end
      end
      cycle();
      budget++;
      if (toggle) out_ready = ~out_ready;
    end
    n_checks++;
    if (idx !== n) $display("FAIL window_count: got %0d words, expected %0d", idx, n);
    else n_pass++;
  endtask

  task automatic test_reset();
    bit ok = 1'b1;
    int tidx, f, l;
    do_reset();
    n_checks++;
    if (rb_wr_en !== 1'b1 || rb_rd_en !== 1'b0 || rb_ain !== '0)
      $display("FAIL reset_rb: wr=%0b rd=%0b ain=%0d, expected 1 0 0", rb_wr_en, rb_rd_en, rb_ain);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_first !== 1'b0 || out_last !== 1'b0)
      $display("FAIL reset_out: valid=%0b data=%0d first=%0b last=%0b, expected all 0",
               out_valid, out_data, out_first, out_last);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || trig_count !== 16'd0)
      $display("FAIL reset_busy_count: busy=%0b count=%0d, expected 0 0", busy, trig_count);
    else n_pass++;
    ramp = 1'b1;
    ext_trig = 1'b1;
    for (int i = 0; i < PRE; i++) begin
      cycle();
      if (rb_wr_en !== 1'b1 || out_valid !== 1'b0) ok = 1'b0;
    end
    n_checks++;
    if (ok !== 1'b1) $display("FAIL fill_wr_en: got wr_en/valid wrong during fill, expected wr=1 valid=0");
    else n_pass++;
    n_checks++;
    if (trig_count !== 16'd0 || busy !== 1'b0)
      $display("FAIL fill_ignores_trig: count=%0d busy=%0b, expected 0 0", trig_count, busy);
    else n_pass++;
    tidx = nsamp;
    cycle();
    ext_trig = 1'b0;
    n_checks++;
    if (trig_count !== 16'd1 || busy !== 1'b1)
      $display("FAIL armed_after_pre: count=%0d busy=%0b, expected 1 1", trig_count, busy);
    else n_pass++;
    drain(WIN, 1'b0, tidx - PRE, f, l);
  endtask

  task automatic test_ext_trig();
    int t, tidx, f, l;
    do_reset();
    ramp = 1'b1;
    wait_value(100);
    t = cyc;
    tidx = nsamp;
    ext_trig = 1'b1;
    cycle();
    ext_trig = 1'b0;
    while (cyc < t + POST - 1) cycle();
    n_checks++;
    if (rb_wr_en !== 1'b1) $display("FAIL post_last_write: wr_en=%0b, expected 1", rb_wr_en);
    else n_pass++;
    cycle();
    n_checks++;
    if (rb_wr_en !== 1'b0 || rb_rd_en !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL read_entry: wr=%0b rd=%0b busy=%0b valid=%0b, expected 0 1 1 0",
               rb_wr_en, rb_rd_en, busy, out_valid);
    else n_pass++;
    drain(WIN, 1'b0, tidx - PRE, f, l);
    n_checks++;
    if (f !== t + POST + 1 || l !== t + 2*POST + PRE)
      $display("FAIL ext_timing: first at %0d last at %0d, expected %0d %0d",
               f - t, l - t, POST + 1, 2*POST + PRE);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0 || rb_wr_en !== 1'b1 || rb_rd_en !== 1'b0 || rb_ain !== '0 ||
        busy !== 1'b0 || trig_count !== 16'd1)
      $display("FAIL ext_done: valid=%0b wr=%0b rd=%0b ain=%0d busy=%0b count=%0d, expected 0 1 0 0 0 1",
               out_valid, rb_wr_en, rb_rd_en, rb_ain, busy, trig_count);
    else n_pass++;
  endtask

  task automatic test_threshold();
    int seq [5];
    int expc [5];
    int tidx, f, l;
    seq = '{490, 499, 500, 501, 600};
    expc = '{0, 0, 0, 1, 1};
    do_reset();
    threshold = 14'd500;
    repeat (PRE) cycle();
    tidx = 0;
    for (int i = 0; i < 5; i++) begin
      adc_in = WIDTH'(seq[i]);
      if (i == 3) tidx = nsamp;
      cycle();
      n_checks++;
      if (int'(trig_count) !== expc[i])
        $display("FAIL thresh_sample_%0d: count=%0d, expected %0d", seq[i], trig_count, expc[i]);
      else n_pass++;
    end
    drain(WIN, 1'b0, tidx - PRE, f, l);
    repeat (60) cycle();
    n_checks++;
    if (trig_count !== 16'd1 || busy !== 1'b0)
      $display("FAIL thresh_no_retrigger: count=%0d busy=%0b, expected 1 0", trig_count, busy);
    else n_pass++;
  endtask

  task automatic test_wrap_backpressure();
    int tidx, f, l;
    do_reset();
    ramp = 1'b1;
    wait_value(250);
    tidx = nsamp;
    ext_trig = 1'b1;
    cycle();
    ext_trig = 1'b0;
    drain(WIN, 1'b1, tidx - PRE, f, l);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || trig_count !== 16'd1)
      $display("FAIL wrap_done: valid=%0b busy=%0b count=%0d, expected 0 0 1", out_valid, busy, trig_count);
    else n_pass++;
  endtask

  task automatic test_ignored_triggers();
    int tidx, f, l;
    do_reset();
    ramp = 1'b1;
    for (int i = 0; i < PRE; i++) begin
      ext_trig = (i == 3 || i == 10);
      cycle();
    end
    ext_trig = 1'b0;
    n_checks++;
    if (trig_count !== 16'd0) $display("FAIL ign_fill: count=%0d, expected 0", trig_count);
    else n_pass++;
    wait_value(30);
    tidx = nsamp;
    ext_trig = 1'b1;
    cycle();
    drain(WIN, 1'b0, tidx - PRE, f, l);
    n_checks++;
    if (trig_count !== 16'd1) $display("FAIL ign_post_read: count=%0d, expected 1", trig_count);
    else n_pass++;
    repeat (PRE) cycle();
    n_checks++;
    if (trig_count !== 16'd1 || busy !== 1'b0)
      $display("FAIL ign_rearm_fill: count=%0d busy=%0b, expected 1 0", trig_count, busy);
    else n_pass++;
    tidx = nsamp;
    cycle();
    ext_trig = 1'b0;
    n_checks++;
    if (trig_count !== 16'd2 || busy !== 1'b1)
      $display("FAIL ign_rearm_trig: count=%0d busy=%0b, expected 2 1", trig_count, busy);
    else n_pass++;
    drain(WIN, 1'b1, tidx - PRE, f, l);
  endtask

  task automatic test_reset_mid_readout();
    int tidx, f, l;
    do_reset();
    ramp = 1'b1;
    wait_value(40);
    tidx = nsamp;
    ext_trig = 1'b1;
    cycle();
    ext_trig = 1'b0;
    drain(10, 1'b0, tidx - PRE, f, l);
    rst = 1'b1;
    cycle();
    n_checks++;
    if (out_valid !== 1'b0 || trig_count !== 16'd0 || busy !== 1'b0 || rb_wr_en !== 1'b1 || rb_rd_en !== 1'b0)
      $display("FAIL midreset_abort: valid=%0b count=%0d busy=%0b wr=%0b rd=%0b, expected 0 0 0 1 0",
               out_valid, trig_count, busy, rb_wr_en, rb_rd_en);
    else n_pass++;
    rst = 1'b0;
    nsamp = 0;
    adc_in = 14'd500;
    ext_trig = 1'b1;
    repeat (PRE) cycle();
    n_checks++;
    if (trig_count !== 16'd0 || out_valid !== 1'b0)
      $display("FAIL midreset_fill: count=%0d valid=%0b, expected 0 0", trig_count, out_valid);
    else n_pass++;
    tidx = nsamp;
    cycle();
    ext_trig = 1'b0;
    n_checks++;
    if (trig_count !== 16'd1) $display("FAIL midreset_retrig: count=%0d, expected 1", trig_count);
    else n_pass++;
    drain(WIN, 1'b0, tidx - PRE, f, l);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL midreset_done: valid=%0b busy=%0b, expected 0 0", out_valid, busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ext_trig();
    test_threshold();
    test_wrap_backpressure();
    test_ignored_triggers();
    test_reset_mid_readout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
